timer_apb_arbiter: RTL and testbench

TIMER_APB_ARBITER -- requirements
Module: timer_apb_arbiter

---
 rtl/timer_apb_arbiter.sv | 156 +++++++++++++++
 tb/tb_timer_apb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_arbiter.sv
// Two-requester round-robin arbiter feeding a single APB master toward the timer.
// Each access runs IDLE -> SETUP -> ACCESS (wait-limited) -> DONE with all outputs registered.
module timer_apb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [11:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_strb,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [11:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_strb,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q;
  logic        last_gnt_q;  // 0 = m0, 1 = m1
  logic        gnt_q;
  logic [7:0]  wait_q;
  logic        busy_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [11:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [3:0]  pstrb_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        pick_m1_d;
  logic        finish_d;
  logic [31:0] rsp_rdata_d;
  logic        rsp_err_d;

  always_comb begin
    pick_m1_d   = m1_req & (~m0_req | ~last_gnt_q);
    finish_d    = tim_pready | (wait_q == TIMEOUT_C);
    // A timeout (pready still low) returns zero data with an error.
    rsp_rdata_d = (tim_pready && !pwrite_q) ? tim_prdata : 32'h0;
    rsp_err_d   = tim_pready ? tim_pslverr : 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      wait_q     <= 8'd0;
      busy_q     <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 12'h0;
      pwdata_q   <= 32'h0;
      pstrb_q    <= 4'h0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q   <= SETUP;
            gnt_q     <= pick_m1_d;
            busy_q    <= 1'b1;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            // NOTE: the APB payload registers are the latched request; they are
            // only loaded here so the bus keeps its last value through DONE and IDLE.
            pwrite_q  <= pick_m1_d ? m1_write : m0_write;
            paddr_q   <= pick_m1_d ? m1_addr  : m0_addr;
            pwdata_q  <= pick_m1_d ? m1_wdata : m0_wdata;
            if (pick_m1_d) pstrb_q <= m1_write ? m1_strb : 4'h0;
            else           pstrb_q <= m0_write ? m0_strb : 4'h0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          wait_q    <= 8'd1;
        end
        ACCESS: begin
          if (finish_d) begin
            state_q    <= DONE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            wait_q     <= 8'd0;
            last_gnt_q <= gnt_q;
            if (gnt_q) begin
              done_q   <= 2'b10;
              err_q    <= {rsp_err_d, 1'b0};
              rdata1_q <= rsp_rdata_d;
            end else begin
              done_q   <= 2'b01;
              err_q    <= {1'b0, rsp_err_d};
              rdata0_q <= rsp_rdata_d;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 2'b00;
          err_q    <= 2'b00;
          rdata0_q <= 32'h0;
          rdata1_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_done     = done_q[0];
  assign m1_done     = done_q[1];
  assign m0_err      = err_q[0];
  assign m1_err      = err_q[1];
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;
  assign arb_busy    = busy_q;

endmodule

// File: tb/tb_timer_apb_arbiter.sv
// Bench for timer_apb_arbiter: directed vector table, hand-written corner sequences,
// and random traffic scored against a transaction-level round-robin model.
module tb_timer_apb_arbiter;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit          req_v   [2];
  bit          wr_v    [2];
  logic [11:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  strb_v  [2];

  logic        pready, pslverr;
  logic [31:0] prdata;

  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        tim_psel, tim_penable, tim_pwrite, arb_busy;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;

  timer_apb_arbiter #(.TIMEOUT(TMO)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .m0_req(req_v[0]), .m0_write(wr_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
    .m0_strb(strb_v[0]), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(req_v[1]), .m1_write(wr_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
    .m1_strb(strb_v[1]), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr),
    .arb_busy(arb_busy)
  );

  typedef struct {
    int          who, steps, n_psel, n_pen;
    logic [31:0] rd;
    logic        er;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wr;
    bit          ok;
  } res_t;

  typedef struct {
    int          who;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          slverr;
    logic [31:0] prdata;
    logic [31:0] exp_rd;
    bit          exp_er;
    int          exp_steps;
    int          exp_acc;
    logic [3:0]  exp_strb;
  } vec_t;

  int          n_pass, n_total;
  int          cfg_waits, acc_cnt;
  bit          cfg_slverr;
  logic [31:0] cfg_prdata;
  int          model_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic bit outs_zero();
    return (m0_done | m1_done | m0_err | m1_err | tim_psel | tim_penable | tim_pwrite | arb_busy) === 1'b0
        && m0_rdata === 32'h0 && m1_rdata === 32'h0 && tim_paddr === 12'h0
        && tim_pwdata === 32'h0 && tim_pstrb === 4'h0;
  endfunction

  // One clock; the bench slave then reacts to what the DUT shows after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tim_psel && tim_penable) begin
      acc_cnt++;
      pready  = (acc_cnt > cfg_waits);
      pslverr = pready ? cfg_slverr : 1'($urandom());
      prdata  = pready ? cfg_prdata : $urandom();
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom());
      pslverr = 1'($urandom());
      prdata  = $urandom();
    end
  endtask

  task automatic set_payload(input int i, input bit wr, input logic [11:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    wr_v[i] = wr; addr_v[i] = a; wdata_v[i] = d; strb_v[i] = s;
  endtask

  // Called at the start of an IDLE cycle; ends at the start of the IDLE cycle after done.
  task automatic run_txn(input int owner, input bit drop, input bit scramble, output res_t r);
    bit got;
    got = 1'b0;
    r = '{who: -1, steps: 0, n_psel: 0, n_pen: 0, rd: 32'h0, er: 1'b0,
          addr: 12'h0, wdata: 32'h0, strb: 4'h0, wr: 1'b0, ok: 1'b1};
    for (int s = 1; s <= 40 && !got; s++) begin
      step();
      if (tim_psel) begin
        if (r.n_psel == 0) begin
          r.addr = tim_paddr; r.wdata = tim_pwdata; r.strb = tim_pstrb; r.wr = tim_pwrite;
        end else if ({tim_paddr, tim_pwdata, tim_pstrb, tim_pwrite} !== {r.addr, r.wdata, r.strb, r.wr})
          r.ok = 1'b0;
        if (!tim_pwrite && tim_pstrb !== 4'h0) r.ok = 1'b0;
        r.n_psel++;
      end
      if (tim_penable) r.n_pen++;
      if (tim_penable && !tim_psel) r.ok = 1'b0;
      if (arb_busy !== 1'b1) r.ok = 1'b0;
      if (!m0_done && (m0_rdata !== 32'h0 || m0_err !== 1'b0)) r.ok = 1'b0;
      if (!m1_done && (m1_rdata !== 32'h0 || m1_err !== 1'b0)) r.ok = 1'b0;
      if (m0_done && m1_done) r.ok = 1'b0;
      if (m0_done || m1_done) begin
        got     = 1'b1;
        r.who   = m1_done ? 1 : 0;
        r.steps = s;
        r.rd    = m1_done ? m1_rdata : m0_rdata;
        r.er    = m1_done ? m1_err : m0_err;
        if (tim_psel || tim_penable) r.ok = 1'b0;
        if ({tim_paddr, tim_pwdata, tim_pstrb, tim_pwrite} !== {r.addr, r.wdata, r.strb, r.wr})
          r.ok = 1'b0;
      end
      if (drop && owner >= 0 && s == 2) req_v[owner] = 1'b0;
      if (scramble && owner >= 0)
        set_payload(owner, 1'($urandom()), 12'($urandom()), $urandom(), 4'($urandom()));
    end
    if (got) begin
      step();
      if (m0_done || m1_done || arb_busy || tim_psel || tim_penable) r.ok = 1'b0;
      if ({tim_paddr, tim_pwdata, tim_pstrb, tim_pwrite} !== {r.addr, r.wdata, r.strb, r.wr})
        r.ok = 1'b0;
    end
  endtask

  task automatic compare_txn(input string tag, input res_t r, input int e_who, input int e_steps,
                             input int e_acc, input logic [31:0] e_rd, input logic e_er,
                             input logic [11:0] e_addr, input logic [31:0] e_wdata,
                             input logic [3:0] e_strb, input logic e_wr);
    check({tag, ".winner"}, r.who, e_who);
    check({tag, ".latency"}, r.steps, e_steps);
    check({tag, ".psel_cycles"}, r.n_psel, e_acc + 1);
    check({tag, ".penable_cycles"}, r.n_pen, e_acc);
    check({tag, ".rdata"}, r.rd, e_rd);
    check({tag, ".err"}, 32'(r.er), 32'(e_er));
    check({tag, ".paddr"}, 32'(r.addr), 32'(e_addr));
    check({tag, ".pwdata"}, r.wdata, e_wdata);
    check({tag, ".pstrb"}, 32'(r.strb), 32'(e_strb));
    check({tag, ".pwrite"}, 32'(r.wr), 32'(e_wr));
    check({tag, ".protocol"}, 32'(r.ok), 32'd1);
  endtask

  function automatic int acc_cycles(input int waits);
    return (waits >= TMO) ? TMO : waits + 1;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: time %0t reached, limit 2ms", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    res_t r;
    n_pass = 0; n_total = 0; acc_cnt = 0; model_last = 1;
    cfg_waits = 0; cfg_slverr = 1'b0; cfg_prdata = 32'h0;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    for (int i = 0; i < 2; i++) set_payload(i, 1'b0, 12'h0, 32'h0, 4'h0);

    //          who wr addr     wdata          strb  waits slverr prdata         exp_rd         er steps acc strb
    vecs[0] = '{0, 1, 12'h004, 32'h0000_0003, 4'hF, 0,    0, 32'h1234_5678, 32'h0,         0, 3,  1,  4'hF};
    vecs[1] = '{1, 0, 12'h008, 32'h5555_AAAA, 4'h7, 3,    0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 6,  4,  4'h0};
    vecs[2] = '{0, 1, 12'hFFC, 32'hA5A5_0001, 4'h3, 0,    1, 32'hFFFF_FFFF, 32'h0,         1, 3,  1,  4'h3};
    vecs[3] = '{1, 1, 12'h010, 32'h0000_00FF, 4'h1, 1,    0, 32'h7777_7777, 32'h0,         0, 4,  2,  4'h1};
    vecs[4] = '{0, 0, 12'h100, 32'h0,         4'hF, 99,   1, 32'hCAFE_F00D, 32'h0,         1, 18, 16, 4'h0};
    vecs[5] = '{1, 0, 12'h7F0, 32'h1,         4'hF, 2,    1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 5,  3,  4'h0};

    // Reset state
    rst = 1'b1;
    step(); step();
    check("reset_outputs_zero", 32'(outs_zero()), 32'd1);
    rst = 1'b0;

    // Contention from reset: m0 first, then strict alternation, one done every 4 cycles
    set_payload(0, 1'b1, 12'h020, 32'h1111_0000, 4'hF);
    set_payload(1, 1'b1, 12'h024, 32'h2222_0000, 4'hF);
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn(-1, 1'b0, 1'b0, r);
      check($sformatf("contend%0d.winner", k), r.who, k % 2);
      check($sformatf("contend%0d.latency", k), r.steps, 3);
      check($sformatf("contend%0d.protocol", k), 32'(r.ok), 32'd1);
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      set_payload(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      req_v[vecs[i].who] = 1'b1;
      cfg_waits = vecs[i].waits; cfg_slverr = vecs[i].slverr; cfg_prdata = vecs[i].prdata;
      run_txn(vecs[i].who, i == 3, 1'b1, r);
      compare_txn($sformatf("vec%0d", i), r, vecs[i].who, vecs[i].exp_steps, vecs[i].exp_acc,
                  vecs[i].exp_rd, vecs[i].exp_er, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_strb, vecs[i].wr);
      req_v[vecs[i].who] = 1'b0;
    end

    // Reset during ACCESS wait states: immediate clear, no done, m0 wins afterwards
    set_payload(1, 1'b0, 12'h044, 32'h0, 4'h0);
    req_v[1] = 1'b1;
    cfg_waits = 99;
    step(); step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs_zero", 32'(outs_zero()), 32'd1);
    step(); step();
    check("reset_hold_no_done", 32'(outs_zero()), 32'd1);
    rst = 1'b0;
    cfg_waits = 0; cfg_slverr = 1'b0;
    set_payload(0, 1'b1, 12'h048, 32'h0000_0042, 4'hC);
    req_v[0] = 1'b1;
    run_txn(0, 1'b0, 1'b0, r);
    check("post_reset.first_winner", r.who, 0);
    check("post_reset.first_latency", r.steps, 3);
    req_v[0] = 1'b0;
    run_txn(1, 1'b0, 1'b0, r);
    check("post_reset.second_winner", r.who, 1);
    req_v[1] = 1'b0;
    model_last = 1;

    // Random traffic against the transaction-level model
    for (int it = 0; it < 80; it++) begin
      int          w, acc;
      bit          tmo, drop;
      logic [11:0] e_addr;
      logic [31:0] e_wdata, e_rd;
      logic [3:0]  e_strb;
      logic        e_wr, e_er;
      for (int i = 0; i < 2; i++)
        if (!req_v[i] && $urandom_range(0, 2) != 0) begin
          req_v[i] = 1'b1;
          set_payload(i, 1'($urandom()), 12'($urandom()), $urandom(), 4'($urandom()));
        end
      if (!req_v[0] && !req_v[1]) begin
        w = int'($urandom_range(0, 1));
        req_v[w] = 1'b1;
        set_payload(w, 1'($urandom()), 12'($urandom()), $urandom(), 4'($urandom()));
      end
      if (req_v[0] && req_v[1]) w = (model_last == 1) ? 0 : 1;
      else                      w = req_v[1] ? 1 : 0;
      e_wr = wr_v[w]; e_addr = addr_v[w]; e_wdata = wdata_v[w];
      e_strb = e_wr ? strb_v[w] : 4'h0;
      cfg_waits  = ($urandom_range(0, 9) == 0) ? TMO - 2 + int'($urandom_range(0, 3))
                                               : int'($urandom_range(0, 4));
      cfg_slverr = 1'($urandom());
      cfg_prdata = $urandom();
      drop = ($urandom_range(0, 4) == 0);
      acc = acc_cycles(cfg_waits);
      tmo = (cfg_waits >= TMO);
      e_rd = (tmo || e_wr) ? 32'h0 : cfg_prdata;
      e_er = tmo ? 1'b1 : cfg_slverr;
      run_txn(w, drop, 1'b1, r);
      compare_txn($sformatf("rnd%0d", it), r, w, acc + 2, acc, e_rd, e_er,
                  e_addr, e_wdata, e_strb, e_wr);
      req_v[w] = 1'b0;
      model_last = w;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
